// File: rtl/gate_check_pkg.sv
// Shared encodings for the gate response checker: FSM state codes and
// truth-table constants for the common 2-input gates, indexed by {a,b}.
package gate_check_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } state_e;

   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NOR  = 4'b0001;

   function automatic logic tt_lookup(input logic [3:0] tt, input logic a, input logic b);
      return tt[{a, b}];
   endfunction

endpackage

// File: rtl/gate_check_sat_counter.sv
// Up-counter that clears synchronously and sticks at its all-ones value
// instead of wrapping.
module gate_check_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      if (v == {W{1'b1}})
         return v;
      return v + W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc)
         q <= sat_inc(q);
   end

endmodule

// File: rtl/gate_response_checker.sv
// Checks (a, b, y) samples from a 2-input gate against a programmable truth table.
// Optional GATE_CHECK_COVERAGE_EN adds cov_mask and makes pass require full coverage.
module gate_response_checker
   import gate_check_pkg::*;
#(
   parameter logic [3:0] TRUTH_TABLE = TT_NAND,
   parameter int         NUM_VECTORS = 4,
   parameter int         CNT_W       = 8,
   parameter int         ERR_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a,
   input  logic             b,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [ERR_W-1:0] err_count,
`ifdef GATE_CHECK_COVERAGE_EN
   output logic [3:0]       cov_mask,
`endif
   output logic [CNT_W-1:0] first_err_idx
);

   state_e state_q;
   state_e state_d;

   logic accept_p0;
   logic mismatch_p0;
   logic last_p0;
   logic run_entry_p0;
   logic cov_full_p0;

   assign in_ready = (state_q == ST_RUN);
   assign busy     = (state_q == ST_RUN);

   // stage p0: classify the sample offered in this cycle
   assign accept_p0    = in_valid & in_ready;
   assign mismatch_p0  = accept_p0 & (y != tt_lookup(TRUTH_TABLE, a, b));
   assign last_p0      = accept_p0 & (vec_count == CNT_W'(NUM_VECTORS - 1));
   assign run_entry_p0 = (state_d == ST_RUN) & (state_q != ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)   state_d = ST_RUN;
         ST_RUN:  if (last_p0) state_d = ST_DONE;
         ST_DONE: if (start)   state_d = ST_RUN;
         default:              state_d = ST_IDLE;
      endcase
   end

   // stage p1: registered counters and run result
   gate_check_sat_counter #(.W(CNT_W)) u_vec_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (run_entry_p0),
      .inc   (accept_p0),
      .q     (vec_count)
   );

   gate_check_sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (run_entry_p0),
      .inc   (mismatch_p0),
      .q     (err_count)
   );

   // err_count never returns to zero within a run, so zero marks "no mismatch yet"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         first_err_idx <= '0;
      else if (run_entry_p0)
         first_err_idx <= '0;
      else if (mismatch_p0 && (err_count == '0))
         first_err_idx <= vec_count;
   end

`ifdef GATE_CHECK_COVERAGE_EN
   logic [3:0] cov_next_p0;

   assign cov_next_p0 = cov_mask | (4'b0001 << {a, b});
   assign cov_full_p0 = (cov_next_p0 == 4'b1111);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cov_mask <= '0;
      else if (run_entry_p0)
         cov_mask <= '0;
      else if (accept_p0)
         cov_mask <= cov_next_p0;
   end
`else
   assign cov_full_p0 = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
         pass <= 1'b0;
      end else begin
         done <= last_p0;
         if (run_entry_p0)
            pass <= 1'b0;
         else if (last_p0)
            pass <= (err_count == '0) & ~mismatch_p0 & cov_full_p0;
      end
   end

endmodule
